// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - pdp11 instruction-trace recorder (circular RAM, pc trigger, halt stop)
// Optional macro CPU_TRACE_TIMESTAMP_EN widens entries to {ts, psw, pc}.
module cpu_trace_buffer #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int ISTATE_W    = 5,
  parameter int FETCH_STATE = 1,
  parameter int HALT_STATE  = 0,
`ifdef CPU_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W    = 48
`else
  localparam int ENTRY_W    = 32
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ISTATE_W-1:0] istate,
  input  logic [15:0]         pc,
  input  logic [15:0]         psw,
  input  logic                arm,
  input  logic                trig_en,
  input  logic [15:0]         trig_pc,
  input  logic [AW:0]         post_cnt,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_idx,
  output logic [ENTRY_W-1:0]  rd_data,
  output logic                rd_valid,
  output logic [AW:0]         count,
  output logic                wrapped,
  output logic                triggered,
  output logic                done,
  output logic [1:0]          state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      raddr;
  logic [AW:0]        post_ctr;
  logic [31:0]        cyc;
  logic [31:0]        cyc_nxt;
  logic               rd_oor;
  logic               capturing;
  logic               sample;
  logic               halt;
  logic               trig_hit;
  logic               we;
  logic [ENTRY_W-1:0] entry;

  assign capturing = (state == RUN) || (state == POST);
  assign sample    = capturing && (istate == ISTATE_W'(FETCH_STATE));
  assign halt      = capturing && (istate == ISTATE_W'(HALT_STATE));
  assign trig_hit  = (state == RUN) && sample && trig_en && (pc == trig_pc);
  // arm wins over any sample on the same edge: the restarted capture begins empty
  assign we        = sample && !arm;
  assign raddr     = (wrapped ? wr_ptr : '0) + rd_idx;
  assign cyc_nxt   = (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;
  assign done      = (state == DONE);
  assign rd_data   = (rd_valid && !rd_oor) ? ram_q : '0;

`ifdef CPU_TRACE_TIMESTAMP_EN
  // ts is the counter value this sample edge produces, i.e. edges since arm
  assign entry = {cyc_nxt[15:0], psw, pc};
`else
  assign entry = {psw, pc};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
      wr_ptr    <= '0;
      post_ctr  <= '0;
      cyc       <= '0;
      rd_valid  <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_oor   <= rd_en && ({1'b0, rd_idx} >= count);
      if (arm) begin
        state     <= RUN;
        count     <= '0;
        wrapped   <= 1'b0;
        triggered <= 1'b0;
        wr_ptr    <= '0;
        post_ctr  <= '0;
        cyc       <= '0;
      end else begin
        cyc <= cyc_nxt;
        if (we) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count == FULL) wrapped <= 1'b1;
          else               count   <= count + 1'b1;
        end
        case (state)
          RUN: begin
            if (trig_hit) begin
              triggered <= 1'b1;
              if (post_cnt == '0 || halt) begin
                state <= DONE;
              end else begin
                state    <= POST;
                post_ctr <= post_cnt;
              end
            end else if (halt) begin
              state <= DONE;
            end
          end
          POST: begin
            if (halt) begin
              state <= DONE;
            end else if (sample) begin
              post_ctr <= post_ctr - 1'b1;
              if (post_ctr == (AW+1)'(1)) state <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // array is not reset; stale data after reset is masked by count
  always_ff @(posedge clk) begin
    if (we)    mem[wr_ptr] <= entry;
    if (rd_en) ram_q       <= mem[raddr];
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesisable instruction-trace recorder for the pdp11 core.
- Samples cpu pc/psw at every instruction boundary into a parametrised circular RAM.
- Supports a pc-match trigger with a programmable post-trigger window and stops on cpu halt.
- Sits beside the cpu on the FPGA top; host logic reads entries back after capture completes.

Parameters:
- DEPTH, 64: trace entries; power of two, 4..1024.
- AW, 6: log2(DEPTH).
- ISTATE_W, 5: width of cpu istate.
- FETCH_STATE, 1: istate value marking an instruction boundary.
- HALT_STATE, 0: istate value meaning cpu halted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- istate  in  ISTATE_W  cpu instruction state
- pc  in  16  cpu program counter
- psw  in  16  cpu processor status word
- arm  in  1  one-cycle pulse; clears buffer and starts capture
- trig_en  in  1  enable pc-match trigger
- trig_pc  in  16  trigger pc value
- post_cnt  in  AW+1  entries stored after trigger, 0..DEPTH
- rd_en  in  1  readout request
- rd_idx  in  AW  entry index, 0 = oldest valid
- rd_data  out  ENTRY_W  entry data, 1 cycle after rd_en
- rd_valid  out  1  qualifies rd_data
- count  out  AW+1  valid entries, saturates at DEPTH
- wrapped  out  1  buffer overwritten at least once
- triggered  out  1  trigger has fired
- done  out  1  capture finished
- state  out  2  IDLE=0, RUN=1, POST=2, DONE=3

Behaviour:
- Reset: state=IDLE; count=0; wrapped=0; triggered=0; done=0; rd_valid=0; rd_data=0; write pointer=0; cycle counter=0.
- Sample event: state is RUN or POST and istate==FETCH_STATE, captured on the rising edge. A sample is stored every cycle the condition holds.
- Entry: {psw, pc}, ENTRY_W=32. With timestamp enabled, ENTRY_W=48 and the entry is {ts, psw, pc}.
- Write pointer increments modulo DEPTH. count increments to DEPTH and then holds. wrapped is set on the first write while count==DEPTH.
- IDLE: arm -> RUN; clears count, wrapped, triggered, done and the write pointer in the same edge.
- RUN:
  - trig_en and sample event with pc==trig_pc -> store the entry, set triggered.
  - If post_cnt==0 -> DONE; otherwise -> POST with post counter=post_cnt.
- POST: each sample decrements the post counter; the sample that brings it to 0 is stored -> DONE.
- Halt: istate==HALT_STATE in RUN or POST -> DONE next edge, no entry stored.
- Halt and trigger on the same edge: the trigger entry is stored, triggered=1, and the next state is DONE.
- DONE: done=1; capture frozen. arm -> RUN (re-arm clears everything, same as from IDLE).
- arm while in RUN or POST: restarts the capture, identical to arm from IDLE.
- Readout:
  - Physical address = (wrapped ? wr_ptr : 0) + rd_idx, modulo DEPTH.
  - rd_data and rd_valid are registered one cycle after rd_en. rd_valid=0 in cycles without a preceding rd_en.
  - rd_idx >= count -> rd_data=0, rd_valid=1.
  - Readout is allowed in any state. A read and write to the same address on the same edge returns the old data.
- Cycle counter: 32-bit, free-running from reset, saturates at 0xFFFFFFFF, cleared on arm.
- RAM: inferred synchronous single-write/single-read block RAM; no reset of array contents.
- reset_n asserted mid-capture: all state returns to reset values immediately and asynchronously. RAM contents are undefined afterwards and are masked by count=0.

Optional Feature:
- Macro: CPU_TRACE_TIMESTAMP_EN.
- Defined: ENTRY_W=48; each entry carries ts = low 16 bits of the cycle counter at the sample edge, stored as {ts, psw, pc}.
- Undefined: ENTRY_W=32; no timestamp field; the cycle counter is still present but unused, and synthesis may remove it.

Test Plan:
- Basic capture: reset, arm, FETCH_STATE on 5 cycles with pc=0o173000,0o173002,...,0o173010 -> count=5, wrapped=0; rd_idx 0..4 return pc 0o173000..0o173010 one cycle after rd_en.
- Wrap: DEPTH=64, 70 samples with pc=2*i -> count=64, wrapped=1; rd_idx=0 returns pc=12, rd_idx=63 returns pc=138.
- Trigger window: trig_en=1, trig_pc=0o1000, post_cnt=3; pc sequence 0o776,0o1000,0o1002,0o1004,0o1006,0o1010 -> triggered=1, done=1 after sample 0o1006, 0o1010 not stored, count=5.
- Halt stop: arm, 3 samples, then istate=0 -> state=DONE next edge, count=3; further FETCH_STATE cycles leave count unchanged.
- Async reset mid-POST: assert reset_n=0 between edges -> state=0, count=0, done=0 with no clock edge; re-arm captures normally.
- Timestamp (macro defined): arm at cycle counter=0; samples on cycles 2 and 7 after arm -> ts fields 2 and 7.
